// File: rtl/sbox_share_ctrl_if.sv
// rtl/sbox_share_ctrl_if.sv - request/response bundle for the shared S-box controller
// Purpose: groups the SubBytes (sb_*) and SubWord (sw_*) handshakes plus busy.
// Ports (master = requester side, slave = controller side):
//   sb_valid/sb_ready/sb_data[127:0]  SubBytes request
//   sb_out_valid/sb_out[127:0]        SubBytes result pulse
//   sw_valid/sw_ready/sw_word[31:0]   SubWord request
//   sw_out_valid/sw_out[31:0]         SubWord result pulse
//   busy                              SubBytes in progress
interface sbox_share_ctrl_if;
  logic         sb_valid;
  logic         sb_ready;
  logic [127:0] sb_data;
  logic         sb_out_valid;
  logic [127:0] sb_out;
  logic         sw_valid;
  logic         sw_ready;
  logic [31:0]  sw_word;
  logic         sw_out_valid;
  logic [31:0]  sw_out;
  logic         busy;

  modport master (
    output sb_valid, sb_data, sw_valid, sw_word,
    input  sb_ready, sb_out_valid, sb_out, sw_ready, sw_out_valid, sw_out, busy
  );

  modport slave (
    input  sb_valid, sb_data, sw_valid, sw_word,
    output sb_ready, sb_out_valid, sb_out, sw_ready, sw_out_valid, sw_out, busy
  );
endinterface

// File: rtl/sbox_share_ctrl.sv
// rtl/sbox_share_ctrl.sv - one bank of SB_LANES AES S-boxes shared by SubBytes and SubWord
// Purpose: SubBytes is processed SB_LANES bytes per cycle over 16/SB_LANES cycles;
//   SubWord uses lanes 0..3 in a single cycle while the controller is idle.
// Ports: clk, rst_n (async, active low), bus (sbox_share_ctrl_if.slave).
// Option: define RR_ARB_EN for round-robin arbitration on simultaneous requests;
//   otherwise SubWord always wins a tie.

// Byte S-box: multiplicative inverse in GF(2^8) (as x^254) followed by the affine map.
module sbox (
  input  logic [7:0] value,
  output logic [7:0] result
);
  localparam logic [7:0] AFF_C = 8'h63;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;

  always_comb begin
    logic [7:0] sq;
    sq  = gf_mul(value, value);
    inv = sq;
    // x^254 = x^2 * x^4 * ... * x^128
    for (int k = 0; k < 6; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    for (int i = 0; i < 8; i++) begin
      result[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^
                  inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ AFF_C[i];
    end
  end
endmodule

module sbox_share_ctrl #(
  parameter int SB_LANES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sbox_share_ctrl_if.slave  bus
);
  localparam int NCYC = 16 / SB_LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int W    = SB_LANES * 8;

  typedef enum logic [0:0] {IDLE, SB_RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    st_q, st_d;
  logic [127:0]    sb_out_q, sb_out_d;
  logic [31:0]     sw_out_q, sw_out_d;
  logic            sb_out_valid_q, sb_out_valid_d;
  logic            sw_out_valid_q, sw_out_valid_d;
`ifdef RR_ARB_EN
  // 0 = SB granted last, 1 = SW granted last
  logic            last_grant_q, last_grant_d;
`endif

  logic [W-1:0]    bank_in;
  logic [W-1:0]    bank_out;
  logic [7:0]      base;
  logic            sw_acc;
  logic            sb_acc;

  for (genvar g = 0; g < SB_LANES; g++) begin : g_bank
    sbox u_sbox (
      .value  (bank_in[g*8 +: 8]),
      .result (bank_out[g*8 +: 8])
    );
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    st_d           = st_q;
    sb_out_d       = sb_out_q;
    sw_out_d       = sw_out_q;
    sb_out_valid_d = 1'b0;
    sw_out_valid_d = 1'b0;
    bus.sb_ready   = 1'b0;
    bus.sw_ready   = 1'b0;
    bank_in        = '0;
    base           = 8'(cnt_q) * 8'(W);
`ifdef RR_ARB_EN
    last_grant_d   = last_grant_q;
`endif

    if (state_q == IDLE) begin
      // Lanes above 3 carry zeros while idle; their results are ignored.
      bank_in[31:0] = bus.sw_word;
`ifdef RR_ARB_EN
      if (bus.sb_valid && bus.sw_valid && last_grant_q) begin
        bus.sb_ready = 1'b1;
        bus.sw_ready = 1'b0;
      end else begin
        bus.sw_ready = 1'b1;
        bus.sb_ready = !bus.sw_valid;
      end
`else
      bus.sw_ready = 1'b1;
      bus.sb_ready = !bus.sw_valid;
`endif
    end else begin
      bank_in = st_q[base +: W];
    end

    sw_acc = bus.sw_valid && bus.sw_ready;
    sb_acc = bus.sb_valid && bus.sb_ready;

    if (sw_acc) begin
      sw_out_d       = bank_out[31:0];
      sw_out_valid_d = 1'b1;
`ifdef RR_ARB_EN
      last_grant_d   = 1'b1;
`endif
    end

    if (sb_acc) begin
      st_d    = bus.sb_data;
      cnt_d   = '0;
      state_d = SB_RUN;
`ifdef RR_ARB_EN
      last_grant_d = 1'b0;
`endif
    end

    if (state_q == SB_RUN) begin
      st_d[base +: W] = bank_out;
      cnt_d           = cnt_q + CW'(1);
      if (cnt_q == CW'(NCYC - 1)) begin
        sb_out_d       = st_d;
        sb_out_valid_d = 1'b1;
        cnt_d          = '0;
        state_d        = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      st_q           <= '0;
      sb_out_q       <= '0;
      sw_out_q       <= '0;
      sb_out_valid_q <= 1'b0;
      sw_out_valid_q <= 1'b0;
`ifdef RR_ARB_EN
      last_grant_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      st_q           <= st_d;
      sb_out_q       <= sb_out_d;
      sw_out_q       <= sw_out_d;
      sb_out_valid_q <= sb_out_valid_d;
      sw_out_valid_q <= sw_out_valid_d;
`ifdef RR_ARB_EN
      last_grant_q   <= last_grant_d;
`endif
    end
  end

  assign bus.sb_out       = sb_out_q;
  assign bus.sw_out       = sw_out_q;
  assign bus.sb_out_valid = sb_out_valid_q;
  assign bus.sw_out_valid = sw_out_valid_q;
  assign bus.busy         = (state_q == SB_RUN);
endmodule
